mac_tile_sched: RTL and testbench

MAC_TILE_SCHED -- requirements
Module: mac_tile_sched

---
 rtl/mac_pkg.sv | 50 +++++
 rtl/mac_tile_cnt.sv | 53 +++++
 rtl/mac_tile_sched.sv | 126 ++++++++++++
 tb/tb_mac_tile_sched.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC tile scheduler: FSM states, tile geometry,
// job-descriptor field positions and per-tile geometry helpers.
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    NEXT  = 3'd4,
    FIN   = 3'd5
  } state_e;

  localparam int TILE    = 4;
  localparam int DIM_MAX = 8;
  localparam int ELEM_W  = 8;

  localparam int FIELD_W = 4;
  localparam int M_LSB   = 8;
  localparam int N_LSB   = 4;
  localparam int T_LSB   = 0;

  function automatic logic field_ok(input logic [3:0] f);
    return (f >= 4'd1) && (f <= 4'(DIM_MAX));
  endfunction

  function automatic logic needs_two(input logic [3:0] dim);
    return dim > 4'(TILE);
  endfunction

  // Number of valid lanes the given tile index covers along one dimension.
  function automatic logic [3:0] tile_cnt(input logic [3:0] dim, input logic idx);
    if (dim <= 4'(TILE)) return dim;
    else if (idx)        return dim - 4'(TILE);
    else                 return 4'(TILE);
  endfunction

  function automatic logic [3:0] vld_mask(input logic [3:0] cnt);
    logic [4:0] full;
    full = (5'd1 << cnt) - 5'd1;
    return full[3:0];
  endfunction

  function automatic logic [4:0] shift_bits(input logic [3:0] nk);
    logic [4:0] gap;
    gap = 5'(TILE) - {1'b0, nk};
    return gap * 5'(ELEM_W);
  endfunction

endpackage

// File: rtl/mac_tile_cnt.sv
// Three-level nested wrap counter (K innermost, then T, then M) walking the
// tile passes of one job; a limit input of 1 means that level has two tiles.
module mac_tile_cnt (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic step_i,
  input  logic k_lim_i,
  input  logic t_lim_i,
  input  logic m_lim_i,
  output logic k_o,
  output logic t_o,
  output logic m_o,
  output logic k_nxt_o,
  output logic t_nxt_o,
  output logic m_nxt_o,
  output logic last_o
);

  logic k_q, t_q, m_q;
  logic k_wrap, t_wrap, m_wrap;

  always_comb begin
    k_wrap  = (k_q == k_lim_i);
    t_wrap  = (t_q == t_lim_i);
    m_wrap  = (m_q == m_lim_i);
    k_nxt_o = k_wrap ? 1'b0 : k_q + 1'b1;
    t_nxt_o = k_wrap ? (t_wrap ? 1'b0 : t_q + 1'b1) : t_q;
    m_nxt_o = (k_wrap && t_wrap) ? (m_wrap ? 1'b0 : m_q + 1'b1) : m_q;
    last_o  = k_wrap && t_wrap && m_wrap;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      k_q <= 1'b0;
      t_q <= 1'b0;
      m_q <= 1'b0;
    end else if (clr_i) begin
      k_q <= 1'b0;
      t_q <= 1'b0;
      m_q <= 1'b0;
    end else if (step_i) begin
      k_q <= k_nxt_o;
      t_q <= t_nxt_o;
      m_q <= m_nxt_o;
    end
  end

  assign k_o = k_q;
  assign t_o = t_q;
  assign m_o = m_q;

endmodule

// File: rtl/mac_tile_sched.sv
// Job scheduler for a 4x4 MAC array: splits an MxN by NxT job into up to eight
// tile passes and presents registered per-tile geometry for each pass.
module mac_tile_sched
  import mac_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        Start,
  input  logic [11:0] MNT,
  input  logic        ArrDone,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic        Clr,
  output logic        TileGo,
  output logic        MTile,
  output logic        TTile,
  output logic        KTile,
  output logic [4:0]  shI,
  output logic [4:0]  shW,
  output logic [3:0]  RowVld,
  output logic [3:0]  ColVld,
  output logic        Acc,
  output logic [3:0]  OBase,
  output logic [2:0]  dbg_state_o
);

  // Handshake: Start is a one-cycle request sampled only in IDLE; ArrDone is
  // sampled only in WAIT; Clr/TileGo/Done/Err are single-cycle pulses.
  state_e      state_q, state_d;
  logic [11:0] mnt_q, mnt_src;
  logic        err_q;
  logic [4:0]  sh_q;
  logic [3:0]  row_q, col_q;
  logic        mnt_valid, accept, advance, last;
  logic        m_idx, t_idx, k_idx, m_nxt, t_nxt, k_nxt;
  logic        m_src, t_src, k_src;

  assign mnt_valid = field_ok(MNT[M_LSB +: FIELD_W]) && field_ok(MNT[N_LSB +: FIELD_W])
                  && field_ok(MNT[T_LSB +: FIELD_W]);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE:  if (Start && mnt_valid) begin
               accept  = 1'b1;
               state_d = INIT;
             end
      INIT:  state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (ArrDone) state_d = NEXT;
      NEXT:  if (last) state_d = FIN;
             else begin
               advance = 1'b1;
               state_d = ISSUE;
             end
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tile geometry is loaded from the incoming descriptor at tile 0 on accept,
  // and from the counter's upcoming indices when stepping to the next pass.
  always_comb begin
    mnt_src = accept ? MNT : mnt_q;
    m_src   = accept ? 1'b0 : m_nxt;
    t_src   = accept ? 1'b0 : t_nxt;
    k_src   = accept ? 1'b0 : k_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      mnt_q   <= '0;
      err_q   <= 1'b0;
      sh_q    <= '0;
      row_q   <= 4'hF;
      col_q   <= 4'hF;
    end else begin
      state_q <= state_d;
      err_q   <= (state_q == IDLE) && Start && !mnt_valid;
      if (accept) mnt_q <= MNT;
      if (accept || advance) begin
        sh_q  <= shift_bits(tile_cnt(mnt_src[N_LSB +: FIELD_W], k_src));
        row_q <= vld_mask(tile_cnt(mnt_src[M_LSB +: FIELD_W], m_src));
        col_q <= vld_mask(tile_cnt(mnt_src[T_LSB +: FIELD_W], t_src));
      end
    end
  end

  mac_tile_cnt u_cnt (
    .clk_i   (CLK),
    .rst_i   (RST),
    .clr_i   (accept),
    .step_i  (advance),
    .k_lim_i (needs_two(mnt_q[N_LSB +: FIELD_W])),
    .t_lim_i (needs_two(mnt_q[T_LSB +: FIELD_W])),
    .m_lim_i (needs_two(mnt_q[M_LSB +: FIELD_W])),
    .k_o     (k_idx),
    .t_o     (t_idx),
    .m_o     (m_idx),
    .k_nxt_o (k_nxt),
    .t_nxt_o (t_nxt),
    .m_nxt_o (m_nxt),
    .last_o  (last)
  );

  assign Busy        = (state_q != IDLE);
  assign Clr         = (state_q == INIT);
  assign TileGo      = (state_q == ISSUE);
  assign Done        = (state_q == FIN);
  assign Err         = err_q;
  assign MTile       = m_idx;
  assign TTile       = t_idx;
  assign KTile       = k_idx;
  assign Acc         = k_idx;
  assign OBase       = {m_idx, t_idx, 2'b00};
  assign shI         = sh_q;
  assign shW         = sh_q;
  assign RowVld      = row_q;
  assign ColVld      = col_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mac_tile_sched.sv
// Directed bench for mac_tile_sched: per-pass tile geometry is captured at each
// TileGo and compared against hand-computed expected tiles.
module tb_mac_tile_sched;

  logic        CLK, RST, Start, ArrDone;
  logic [11:0] MNT;
  logic        Busy, Done, Err, Clr, TileGo, MTile, TTile, KTile, Acc;
  logic [4:0]  shI, shW;
  logic [3:0]  RowVld, ColVld, OBase;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [25:0] exp_q[$];
  logic [25:0] obs_q[$];
  bit g_clr_seen, g_first_go, g_done, g_lat_ok;
  int g_passes;

  mac_tile_sched dut (
    .CLK(CLK), .RST(RST), .Start(Start), .MNT(MNT), .ArrDone(ArrDone),
    .Busy(Busy), .Done(Done), .Err(Err), .Clr(Clr), .TileGo(TileGo),
    .MTile(MTile), .TTile(TTile), .KTile(KTile), .shI(shI), .shW(shW),
    .RowVld(RowVld), .ColVld(ColVld), .Acc(Acc), .OBase(OBase),
    .dbg_state_o(dbg_state)
  );

  // Clock and reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [25:0] tv(input logic m, t, k, input logic [4:0] sh,
                                     input logic [3:0] row, col, input logic acc,
                                     input logic [3:0] ob);
    return {m, t, k, sh, sh, row, col, acc, ob};
  endfunction

  function automatic logic [25:0] cur_tile();
    return {MTile, TTile, KTile, shI, shW, RowVld, ColVld, Acc, OBase};
  endfunction

  // Driver: answers one pass, entered at the ISSUE negedge; optional noise puts
  // ArrDone in ISSUE and Start (with a different MNT) in WAIT.
  task automatic respond_pass(input bit noise);
    if (noise) ArrDone = 1'b1;
    @(negedge CLK);
    ArrDone = 1'b0;
    if (noise) begin
      Start = 1'b1;
      MNT   = 12'h111;
    end
    @(negedge CLK);
    Start = 1'b0;
    @(negedge CLK);
    ArrDone = 1'b1;
    @(negedge CLK);
    ArrDone = 1'b0;
    @(negedge CLK);
    if (!(TileGo || Done)) g_lat_ok = 1'b0;
  endtask

  task automatic run_job(input logic [11:0] mnt, input bit noise);
    g_passes = 0; g_done = 1'b0; g_lat_ok = 1'b1;
    obs_q.delete();
    Start = 1'b1; MNT = mnt;
    @(negedge CLK);
    Start = 1'b0;
    g_clr_seen = Clr;
    @(negedge CLK);
    g_first_go = TileGo;
    for (int cyc = 0; cyc < 300 && !g_done; cyc++) begin
      if (Done) g_done = 1'b1;
      else if (TileGo) begin
        obs_q.push_back(cur_tile());
        g_passes++;
        respond_pass(noise);
      end else @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; Start = 1'b0; ArrDone = 1'b0; MNT = '0;
    @(negedge CLK);
    n_checks++;
    if ({Busy, Done, Err, Clr, TileGo} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctl: got %b expected 00000", {Busy, Done, Err, Clr, TileGo});
    end
    n_checks++;
    if (cur_tile() !== tv(0, 0, 0, 5'd0, 4'hF, 4'hF, 0, 4'd0)) begin
      n_fail++; $display("FAIL reset_tile: got %h expected %h", cur_tile(), tv(0, 0, 0, 5'd0, 4'hF, 4'hF, 0, 4'd0));
    end
    n_checks++;
    if (dbg_state !== 3'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    RST = 1'b0;
  endtask

  task automatic test_single();
    logic [25:0] e, o;
    exp_q.push_back(tv(0, 0, 0, 5'd0, 4'hF, 4'hF, 0, 4'd0));
    run_job(12'h444, 1'b0);
    n_checks++;
    if ({g_clr_seen, g_first_go, g_done, g_lat_ok} !== 4'b1111) begin
      n_fail++; $display("FAIL single_timing: got clr/go/done/lat=%b expected 1111", {g_clr_seen, g_first_go, g_done, g_lat_ok});
    end
    n_checks++;
    if (g_passes != 1) begin n_fail++; $display("FAIL single_passes: got %0d expected 1", g_passes); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL single_tile: got %h expected %h", o, e); end
    end
    @(negedge CLK);
    n_checks++;
    if ({Busy, Done} !== 2'b00) begin n_fail++; $display("FAIL single_idle: got busy/done=%b expected 00", {Busy, Done}); end
  endtask

  task automatic test_full(input bit noise);
    logic [25:0] e, o;
    logic [2:0] mtk;
    logic [3:0] ob [8] = '{4'd0, 4'd0, 4'd4, 4'd4, 4'd8, 4'd8, 4'd12, 4'd12};
    for (int i = 0; i < 8; i++) begin
      mtk = 3'(i);
      exp_q.push_back(tv(mtk[2], mtk[1], mtk[0], 5'd0, 4'hF, 4'hF, mtk[0], ob[i]));
    end
    run_job(12'h888, noise);
    n_checks++;
    if ({g_clr_seen, g_first_go, g_done, g_lat_ok} !== 4'b1111) begin
      n_fail++; $display("FAIL full_timing noise=%0d: got %b expected 1111", noise, {g_clr_seen, g_first_go, g_done, g_lat_ok});
    end
    n_checks++;
    if (g_passes != 8) begin n_fail++; $display("FAIL full_passes noise=%0d: got %0d expected 8", noise, g_passes); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL full_tile%0d noise=%0d: got %h expected %h", i, noise, o, e); end
    end
    @(negedge CLK);
  endtask

  task automatic test_partial();
    logic [25:0] e, o;
    exp_q.push_back(tv(0, 0, 0, 5'd0,  4'h7, 4'hF, 0, 4'd0));
    exp_q.push_back(tv(0, 0, 1, 5'd16, 4'h7, 4'hF, 1, 4'd0));
    exp_q.push_back(tv(0, 1, 0, 5'd0,  4'h7, 4'h1, 0, 4'd4));
    exp_q.push_back(tv(0, 1, 1, 5'd16, 4'h7, 4'h1, 1, 4'd4));
    run_job(12'h365, 1'b0);
    n_checks++;
    if ({g_done, g_lat_ok, g_passes == 4} !== 3'b111) begin
      n_fail++; $display("FAIL partial_run: got done/lat=%b passes=%0d expected 11 and 4", {g_done, g_lat_ok}, g_passes);
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL partial_tile%0d: got %h expected %h", i, o, e); end
    end
    @(negedge CLK);
  endtask

  task automatic test_invalid();
    logic [11:0] bad [2] = '{12'h048, 12'h894};
    for (int i = 0; i < 2; i++) begin
      Start = 1'b1; MNT = bad[i];
      @(negedge CLK);
      Start = 1'b0;
      n_checks++;
      if ({Err, Busy, Clr} !== 3'b100) begin
        n_fail++; $display("FAIL invalid_%h_pulse: got err/busy/clr=%b expected 100", bad[i], {Err, Busy, Clr});
      end
      @(negedge CLK);
      n_checks++;
      if ({Err, Busy, Clr} !== 3'b000) begin
        n_fail++; $display("FAIL invalid_%h_after: got err/busy/clr=%b expected 000", bad[i], {Err, Busy, Clr});
      end
    end
  endtask

  task automatic test_back_to_back();
    run_job(12'h444, 1'b0);
    Start = 1'b1; MNT = 12'h444;
    @(negedge CLK);
    Start = 1'b0;
    n_checks++;
    if ({g_done, Busy, Clr, Err} !== 4'b1000) begin
      n_fail++; $display("FAIL start_in_fin: got done/busy/clr/err=%b expected 1000", {g_done, Busy, Clr, Err});
    end
    run_job(12'h365, 1'b0);
    n_checks++;
    if ({g_clr_seen, g_done} !== 2'b11 || g_passes != 4) begin
      n_fail++; $display("FAIL b2b_followup: got clr/done=%b passes=%0d expected 11 and 4", {g_clr_seen, g_done}, g_passes);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    int go;
    logic [25:0] o;
    go = 0;
    Start = 1'b1; MNT = 12'h888;
    @(negedge CLK);
    Start = 1'b0;
    for (int cyc = 0; cyc < 200 && go < 3; cyc++) begin
      if (TileGo) begin
        go++;
        if (go < 3) respond_pass(1'b0);
      end else @(negedge CLK);
    end
    @(negedge CLK);
    n_checks++;
    if (go != 3 || dbg_state !== 3'd3) begin
      n_fail++; $display("FAIL mid_reach_wait: got passes=%0d state=%0d expected 3 and 3", go, dbg_state);
    end
    RST = 1'b1;
    #1;
    n_checks++;
    if ({Busy, dbg_state} !== 4'b0) begin
      n_fail++; $display("FAIL mid_async: got busy=%b state=%0d expected 0 and 0", Busy, dbg_state);
    end
    n_checks++;
    if (cur_tile() !== tv(0, 0, 0, 5'd0, 4'hF, 4'hF, 0, 4'd0)) begin
      n_fail++; $display("FAIL mid_tile_reset: got %h expected %h", cur_tile(), tv(0, 0, 0, 5'd0, 4'hF, 4'hF, 0, 4'd0));
    end
    @(negedge CLK);
    RST = 1'b0;
    run_job(12'h444, 1'b0);
    o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
    n_checks++;
    if ({g_clr_seen, g_first_go, g_done} !== 3'b111 || g_passes != 1) begin
      n_fail++; $display("FAIL mid_restart: got clr/go/done=%b passes=%0d expected 111 and 1", {g_clr_seen, g_first_go, g_done}, g_passes);
    end
    n_checks++;
    if (o !== tv(0, 0, 0, 5'd0, 4'hF, 4'hF, 0, 4'd0)) begin
      n_fail++; $display("FAIL mid_restart_tile: got %h expected %h", o, tv(0, 0, 0, 5'd0, 4'hF, 4'hF, 0, 4'd0));
    end
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_single();
    test_full(1'b0);
    test_partial();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    test_full(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
